// File: rtl/fpall_issue_arbiter.sv
// Round-robin issue arbiter sharing one pipelined FP unit among N requesters.
// A format change drains the unit before the new format is issued.
module fpall_issue_arbiter #(
   parameter int N_REQ = 4,
   parameter int LAT   = 3,
   parameter int IDW   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [2*N_REQ-1:0]   req_opcode,
   input  logic [N_REQ-1:0]     req_fmt,
   input  logic [32*N_REQ-1:0]  req_x,
   input  logic [32*N_REQ-1:0]  req_y,
   output logic [1:0]           fpu_opcode,
   output logic                 fpu_fmt,
   output logic [31:0]          fpu_x,
   output logic [31:0]          fpu_y,
   input  logic [31:0]          fpu_r,
   output logic                 resp_valid,
   output logic [IDW-1:0]       resp_id,
   output logic [31:0]          resp_r,
   output logic                 busy
);

   typedef enum logic {RUN, DRAIN} state_t;

   localparam int CW = $clog2(LAT + 2);

   state_t               state;
   state_t               state_nxt;
   logic                 cur_fmt;
   logic                 cur_fmt_nxt;
   logic [IDW-1:0]       rr;
   logic [IDW-1:0]       rr_nxt;
   logic [IDW-1:0]       drain_id;
   logic [IDW-1:0]       drain_id_nxt;
   logic [IDW-1:0]       win_id;
   logic [IDW-1:0]       idx;
   logic                 win_found;
   logic                 grant;
   logic [IDW-1:0]       grant_id;
   logic [LAT:0]         tag_v;
   logic [LAT:0][IDW-1:0] tag_id;
   logic [CW-1:0]        inflight;

   assign inflight = CW'($countones(tag_v));
   assign busy     = (inflight != '0) || (state == DRAIN);

   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      idx       = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = IDW'((int'(rr) + k) % N_REQ);
         if (!win_found && req_valid[idx]) begin
            win_found = 1'b1;
            win_id    = idx;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      cur_fmt_nxt  = cur_fmt;
      rr_nxt       = rr;
      drain_id_nxt = drain_id;
      grant        = 1'b0;
      grant_id     = win_id;
      unique case (state)
         RUN: begin
            if (win_found) begin
               if (req_fmt[win_id] == cur_fmt || inflight == '0) begin
                  grant = 1'b1;
               end else begin
                  state_nxt    = DRAIN;
                  drain_id_nxt = win_id;
               end
            end
         end
         DRAIN: begin
            grant_id = drain_id;
            // A withdrawn switcher releases the drain immediately.
            if (!req_valid[drain_id]) begin
               state_nxt = RUN;
            end else if (inflight == '0) begin
               grant     = 1'b1;
               state_nxt = RUN;
            end
         end
         default: state_nxt = RUN;
      endcase
      if (grant) begin
         cur_fmt_nxt = req_fmt[grant_id];
         rr_nxt = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
      end
   end

   assign req_ready = (grant && !rst) ? (N_REQ'(1) << grant_id) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         cur_fmt    <= 1'b0;
         rr         <= '0;
         drain_id   <= '0;
         tag_v      <= '0;
         tag_id     <= '0;
         fpu_opcode <= '0;
         fpu_fmt    <= 1'b0;
         fpu_x      <= '0;
         fpu_y      <= '0;
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_r     <= '0;
      end else begin
         state    <= state_nxt;
         cur_fmt  <= cur_fmt_nxt;
         rr       <= rr_nxt;
         drain_id <= drain_id_nxt;
         tag_v    <= {tag_v[LAT-1:0], grant};
         tag_id   <= {tag_id[LAT-1:0], grant_id};
         fpu_fmt  <= cur_fmt_nxt;
         if (grant) begin
            fpu_opcode <= req_opcode[{grant_id, 1'b0} +: 2];
            fpu_x      <= req_x[{grant_id, 5'd0} +: 32];
            fpu_y      <= req_y[{grant_id, 5'd0} +: 32];
         end else begin
            fpu_opcode <= '0;
            fpu_x      <= '0;
            fpu_y      <= '0;
         end
         resp_valid <= tag_v[LAT];
         if (tag_v[LAT]) begin
            resp_id <= tag_id[LAT];
            resp_r  <= fpu_r;
         end
      end
   end

endmodule

// File: tb/tb_fpall_issue_arbiter.sv
// Bench for fpall_issue_arbiter: vector table, directed corner sequences
// and random traffic against a transaction-level reference model.
module tb_fpall_issue_arbiter;

   localparam int N   = 4;
   localparam int LAT = 3;
   localparam int IDW = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [2*N-1:0]   req_opcode;
   logic [N-1:0]     req_fmt;
   logic [32*N-1:0]  req_x;
   logic [32*N-1:0]  req_y;
   logic [1:0]       fpu_opcode;
   logic             fpu_fmt;
   logic [31:0]      fpu_x;
   logic [31:0]      fpu_y;
   logic [31:0]      fpu_r;
   logic             resp_valid;
   logic [IDW-1:0]   resp_id;
   logic [31:0]      resp_r;
   logic             busy;

   fpall_issue_arbiter #(.N_REQ(N), .LAT(LAT), .IDW(IDW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_fmt(req_fmt),
      .req_x(req_x), .req_y(req_y),
      .fpu_opcode(fpu_opcode), .fpu_fmt(fpu_fmt),
      .fpu_x(fpu_x), .fpu_y(fpu_y), .fpu_r(fpu_r),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_r(resp_r),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Stand-in FP unit: known test-plan results, otherwise a mixing hash.
   function automatic logic [31:0] fpu_fn(logic [1:0] op, logic f,
                                          logic [31:0] x, logic [31:0] y);
      if (op == 2'b00 && !f && x == 32'h3F800000 && y == 32'h40000000)
         return 32'h40400000;
      if (op == 2'b01 && !f && x == 32'h40000000 && y == 32'h40400000)
         return 32'h40C00000;
      if (op == 2'b00 && f && x == 32'h00003C00 && y == 32'h00003C00)
         return 32'h00004000;
      return (x ^ {y[15:0], y[31:16]}) + {28'h0, f, 1'b0, op};
   endfunction

   logic [31:0] fq [LAT];
   always @(posedge clk) begin
      fq[0] <= fpu_fn(fpu_opcode, fpu_fmt, fpu_x, fpu_y);
      for (int k = 1; k < LAT; k++) fq[k] <= fq[k-1];
   end
   assign fpu_r = fq[LAT-1];

   typedef struct {
      int h; int id; logic [1:0] op; logic f;
      logic [31:0] x; logic [31:0] y; logic [31:0] r;
   } iss_t;
   typedef struct { int c; int id; logic [31:0] r; } rl_t;
   typedef struct { logic [N-1:0] v; logic [N-1:0] exp; } vec_t;

   iss_t iq [$];
   rl_t  rlog [$];
   int   n_err = 0;
   int   n_chk = 0;
   int   cyc = 0;
   int   m_rr, m_did, n_rr, n_did;
   bit   m_drain, n_drain;
   logic m_fmt, n_fmt;
   logic [N-1:0]    last_ready, last_g, pv;
   logic            last_rst = 1'b1;
   logic [32*N-1:0] px, py;
   logic [2*N-1:0]  pop;
   logic [N-1:0]    pf;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int inflight_at(int c);
      int n = 0;
      foreach (iq[k]) if (iq[k].h >= c - LAT && iq[k].h <= c) n++;
      return n;
   endfunction

   task automatic model_reset();
      iq.delete();
      m_rr = 0; m_did = 0; m_drain = 0; m_fmt = 1'b0;
   endtask

   task automatic model_eval(output logic [N-1:0] g);
      int w, infl;
      g = '0; w = -1;
      n_rr = m_rr; n_did = m_did; n_drain = m_drain; n_fmt = m_fmt;
      infl = inflight_at(cyc);
      for (int k = 0; k < N; k++)
         if (w < 0 && req_valid[(m_rr + k) % N +: 1] == 1'b1) w = (m_rr + k) % N;
      if (!m_drain) begin
         if (w >= 0) begin
            if (req_fmt[w +: 1] == m_fmt || infl == 0) g[w +: 1] = 1'b1;
            else begin n_drain = 1; n_did = w; end
         end
      end else if (req_valid[m_did +: 1] == 1'b0) begin
         n_drain = 0;
      end else if (infl == 0) begin
         g[m_did +: 1] = 1'b1; n_drain = 0;
      end
      for (int i = 0; i < N; i++)
         if (g[i +: 1] == 1'b1) begin n_fmt = req_fmt[i +: 1]; n_rr = (i + 1) % N; end
   endtask

   task automatic model_commit(input logic [N-1:0] g);
      iss_t e;
      m_rr = n_rr; m_did = n_did; m_drain = n_drain; m_fmt = n_fmt;
      for (int i = 0; i < N; i++)
         if (g[i +: 1] == 1'b1) begin
            e.h = cyc + 1; e.id = i;
            e.op = req_opcode[2*i +: 2]; e.f = req_fmt[i +: 1];
            e.x = req_x[32*i +: 32]; e.y = req_y[32*i +: 32];
            e.r = fpu_fn(e.op, e.f, e.x, e.y);
            iq.push_back(e);
         end
   endtask

   task automatic check_outputs();
      logic [31:0] ex, ey, er;
      logic [1:0]  eop;
      logic        ef, ev;
      int          eid;
      while (iq.size() > 0 && iq[0].h + LAT + 1 < cyc) void'(iq.pop_front());
      ex = '0; ey = '0; eop = '0; ef = m_fmt; ev = 1'b0; eid = 0; er = '0;
      foreach (iq[k]) begin
         if (iq[k].h == cyc) begin
            ex = iq[k].x; ey = iq[k].y; eop = iq[k].op; ef = iq[k].f;
         end
         if (iq[k].h + LAT + 1 == cyc) begin
            ev = 1'b1; eid = iq[k].id; er = iq[k].r;
         end
      end
      chk("fpu_x", fpu_x, ex);
      chk("fpu_y", fpu_y, ey);
      chk("fpu_opcode", 32'(fpu_opcode), 32'(eop));
      chk("fpu_fmt", 32'(fpu_fmt), 32'(ef));
      chk("resp_valid", 32'(resp_valid), 32'(ev));
      if (ev) begin
         chk("resp_id", 32'(resp_id), eid);
         chk("resp_r", resp_r, er);
      end
      chk("busy", 32'(busy), 32'(inflight_at(cyc) > 0 || m_drain));
      if (resp_valid) rlog.push_back('{cyc, int'(resp_id), resp_r});
   endtask

   task automatic hold_check();
      for (int i = 0; i < N; i++)
         if (!last_rst && pv[i +: 1] == 1'b1 && last_g[i +: 1] == 1'b0
             && req_valid[i +: 1] == 1'b1) begin
            chk("hold_x", req_x[32*i +: 32], px[32*i +: 32]);
            chk("hold_y", req_y[32*i +: 32], py[32*i +: 32]);
            chk("hold_op", {29'h0, req_opcode[2*i +: 2], req_fmt[i +: 1]},
                {29'h0, pop[2*i +: 2], pf[i +: 1]});
         end
   endtask

   // Called at a falling edge with inputs already driven.
   task automatic tick();
      logic [N-1:0] g;
      #1;
      hold_check();
      g = '0;
      if (!rst) model_eval(g);
      chk("req_ready", 32'(req_ready), 32'(g));
      last_ready = req_ready; last_g = g; last_rst = rst;
      pv = req_valid; pop = req_opcode; pf = req_fmt; px = req_x; py = req_y;
      @(posedge clk);
      if (rst) model_reset(); else model_commit(g);
      cyc++;
      @(negedge clk);
      check_outputs();
   endtask

   task automatic set_req(int i, logic [1:0] op, logic f,
                          logic [31:0] x, logic [31:0] y);
      req_valid[i +: 1] = 1'b1;
      req_opcode[2*i +: 2] = op;
      req_fmt[i +: 1] = f;
      req_x[32*i +: 32] = x;
      req_y[32*i +: 32] = y;
   endtask

   task automatic idle_all();
      req_valid = '0;
   endtask

   task automatic do_reset();
      idle_all();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_resp_valid", 32'(resp_valid), 0);
      chk("rst_resp_id", 32'(resp_id), 0);
      chk("rst_resp_r", resp_r, 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_fpu_x", fpu_x, 0);
      chk("rst_fpu_fmt", 32'(fpu_fmt), 0);
      rlog.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl [12];
      int   c0, off, cnt [N];
      logic [N-1:0] got;
      tbl[0]  = '{4'b1111, 4'b0001};
      tbl[1]  = '{4'b1111, 4'b0010};
      tbl[2]  = '{4'b0001, 4'b0001};
      tbl[3]  = '{4'b1000, 4'b1000};
      tbl[4]  = '{4'b0000, 4'b0000};
      tbl[5]  = '{4'b0110, 4'b0010};
      tbl[6]  = '{4'b0110, 4'b0100};
      tbl[7]  = '{4'b0011, 4'b0001};
      tbl[8]  = '{4'b1100, 4'b0100};
      tbl[9]  = '{4'b1011, 4'b1000};
      tbl[10] = '{4'b1011, 4'b0001};
      tbl[11] = '{4'b1010, 4'b0010};

      rst = 1'b1;
      req_valid = '0; req_opcode = '0; req_fmt = '0; req_x = '0; req_y = '0;
      model_reset();
      @(negedge clk);
      do_reset();

      for (int i = 0; i < N; i++) set_req(i, 2'b00, 1'b0, 32'(i), 32'(i + 9));
      foreach (tbl[t]) begin
         req_valid = tbl[t].v;
         tick();
         chk($sformatf("rr_table_%0d", t), 32'(last_ready), 32'(tbl[t].exp));
      end
      idle_all();
      repeat (6) tick();

      // Single op latency
      do_reset();
      c0 = cyc;
      set_req(0, 2'b00, 1'b0, 32'h3F800000, 32'h40000000);
      tick();
      chk("single_ready", 32'(last_ready), 32'h1);
      chk("single_fpu_x", fpu_x, 32'h3F800000);
      chk("single_fpu_y", fpu_y, 32'h40000000);
      idle_all();
      repeat (8) tick();
      chk("single_nresp", rlog.size(), 1);
      if (rlog.size() > 0) begin
         chk("single_latency", rlog[0].c - c0, LAT + 2);
         chk("single_id", rlog[0].id, 0);
         chk("single_r", rlog[0].r, 32'h40400000);
      end

      // Back-to-back issue from one requester
      do_reset();
      c0 = cyc;
      for (int k = 0; k < 4; k++) begin
         set_req(1, 2'b01, 1'b0, 32'h40000000, 32'h40400000);
         tick();
         chk("b2b_ready", 32'(last_ready), 32'h2);
      end
      idle_all();
      repeat (8) tick();
      chk("b2b_nresp", rlog.size(), 4);
      foreach (rlog[k]) begin
         chk("b2b_cycle", rlog[k].c, c0 + LAT + 2 + k);
         chk("b2b_id", rlog[k].id, 1);
         chk("b2b_r", rlog[k].r, 32'h40C00000);
      end

      // Round-robin fairness over 40 cycles
      do_reset();
      for (int i = 0; i < N; i++) begin
         cnt[i] = 0;
         set_req(i, 2'(i), 1'b0, 32'(i * 3), 32'(i * 5));
      end
      for (int n = 0; n < 40; n++) begin
         tick();
         chk("rr_order", 32'(last_ready), 32'(1) << (n % N));
         for (int i = 0; i < N; i++) if (last_ready[i +: 1] == 1'b1) cnt[i]++;
      end
      for (int i = 0; i < N; i++) chk($sformatf("rr_share_%0d", i), cnt[i], 10);
      idle_all();
      repeat (6) tick();

      // Format switch drains the unit, then back again
      do_reset();
      set_req(0, 2'b00, 1'b0, 32'h3F800000, 32'h40000000);
      tick();
      chk("fs_g0a", 32'(last_ready), 32'h1);
      set_req(0, 2'b01, 1'b0, 32'h40000000, 32'h40400000);
      tick();
      chk("fs_g0b", 32'(last_ready), 32'h1);
      set_req(0, 2'b00, 1'b0, 32'h11111111, 32'h22222222);
      set_req(1, 2'b00, 1'b1, 32'h00003C00, 32'h00003C00);
      off = -1; got = '0;
      for (int j = 0; j < 20 && off < 0; j++) begin
         tick();
         if (last_ready != '0) begin off = j; got = last_ready; end
      end
      chk("fs_stall", off, 4);
      chk("fs_grant", 32'(got), 32'h2);
      chk("fs_fpu_fmt", 32'(fpu_fmt), 1);
      chk("fs_fpu_x", fpu_x, 32'h00003C00);
      req_valid[1] = 1'b0;
      off = -1; got = '0;
      for (int j = 0; j < 20 && off < 0; j++) begin
         tick();
         if (last_ready != '0) begin off = j; got = last_ready; end
      end
      chk("fs_stall2", off, 4);
      chk("fs_grant2", 32'(got), 32'h1);
      idle_all();
      repeat (8) tick();
      chk("fs_nresp", rlog.size(), 4);
      foreach (rlog[k])
         if (rlog[k].id == 1) chk("fs_r16", rlog[k].r, 32'h00004000);

      // Drain abort leaves format and pointer alone
      do_reset();
      set_req(0, 2'b00, 1'b0, 32'h1, 32'h2);
      tick();
      chk("da_g0", 32'(last_ready), 32'h1);
      idle_all();
      set_req(2, 2'b11, 1'b1, 32'h5, 32'h6);
      tick();
      chk("da_enter", 32'(last_ready), 0);
      chk("da_busy", 32'(busy), 1);
      req_valid[2] = 1'b0;
      set_req(3, 2'b01, 1'b0, 32'h7, 32'h8);
      tick();
      chk("da_abort", 32'(last_ready), 0);
      tick();
      chk("da_run", 32'(last_ready), 32'h8);
      chk("da_fmt", 32'(fpu_fmt), 0);
      idle_all();
      repeat (6) tick();

      // Reset with ops in flight
      do_reset();
      for (int k = 0; k < 3; k++) begin
         set_req(0, 2'b00, 1'b1, 32'(k + 1), 32'(k + 2));
         tick();
      end
      idle_all();
      rlog.delete();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rm_busy", 32'(busy), 0);
      chk("rm_fmt", 32'(fpu_fmt), 0);
      repeat (8) tick();
      chk("rm_nresp", rlog.size(), 0);
      for (int i = 0; i < N; i++) set_req(i, 2'b00, 1'b0, 32'(i), 32'(i));
      tick();
      chk("rm_rr", 32'(last_ready), 32'h1);
      idle_all();
      repeat (6) tick();

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 399) == 0);
         for (int i = 0; i < N; i++) begin
            if (!last_rst && req_valid[i +: 1] == 1'b1 && last_g[i +: 1] == 1'b0) begin
               if ($urandom_range(0, 19) == 0) req_valid[i +: 1] = 1'b0;
            end else if ($urandom_range(0, 99) < 45) begin
               set_req(i, 2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 2),
                       $urandom, $urandom);
            end else begin
               req_valid[i +: 1] = 1'b0;
            end
         end
         tick();
      end
      rst = 1'b0;
      idle_all();
      repeat (8) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/fpall_issue_arbiter.md
Name: fpall_issue_arbiter

Overview:
Shares one fixed-latency pipelined FP unit (Add/Mul/Sqrt/Div, FP32/FP16 formats) between N requesters. Round-robin arbitration, at most one issue per cycle. Each result is routed back with the requester ID, using a tag pipeline that mirrors the unit's latency. A format change drains the unit first, because the shared datapath is configured per format.

Parameters:
N_REQ, 4, number of requesters (2..8)
LAT, 3, cycles from fpu_* inputs valid to fpu_r valid (>=1)
IDW, 2, requester ID width, equals clog2(N_REQ)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  N_REQ  per-requester operation valid
req_ready  out  N_REQ  per-requester grant (combinational from state and req_valid)
req_opcode  in  2*N_REQ  per-requester opcode: 00 Add, 01 Mul, 10 Sqrt, 11 Div
req_fmt  in  N_REQ  per-requester format: 0 FP32, 1 FP16
req_x  in  32*N_REQ  per-requester operand X
req_y  in  32*N_REQ  per-requester operand Y
fpu_opcode  out  2  opcode to shared unit (registered)
fpu_fmt  out  1  format to shared unit (registered)
fpu_x  out  32  operand X to shared unit (registered)
fpu_y  out  32  operand Y to shared unit (registered)
fpu_r  in  32  result from shared unit
resp_valid  out  1  result valid, single-cycle pulse, no backpressure
resp_id  out  IDW  requester that owns resp_r
resp_r  out  32  registered result
busy  out  1  high when any op is in flight or state is DRAIN

Behaviour:
- Handshake: a transfer occurs at an edge where req_valid[i] and req_ready[i] are both high. At most one req_ready bit is high per cycle.
- Issue timing for a handshake at edge t:
  - fpu_* carry that op during cycle t+1 only.
  - fpu_r is sampled at the end of cycle t+1+LAT.
  - resp_valid/resp_id/resp_r are high in cycle t+2+LAT.
  - Total latency is LAT+2.
- Idle cycles: fpu_x=0, fpu_y=0, fpu_opcode=00, fpu_fmt holds cur_fmt.
- Tag pipeline: LAT+1 stages, each holding {valid, id}; it advances every cycle. Stage 0 is loaded at handshake. The final stage drives resp_*. inflight = number of valid stages.
- Round-robin:
  - The pointer rr starts at 0.
  - The winner is the first valid requester scanning rr, rr+1, ... mod N_REQ.
  - After a grant to i, rr becomes (i+1) mod N_REQ.
  - rr is unchanged when nothing is granted.
- FSM states RUN and DRAIN; cur_fmt register.
- In RUN:
  - If the winner's fmt equals cur_fmt, or inflight==0: grant the winner and set cur_fmt to the winner's fmt.
  - Otherwise: no grant, latch drain_id=winner, go to DRAIN.
- In DRAIN:
  - No grants while inflight!=0.
  - When inflight==0: grant drain_id only if req_valid[drain_id], update cur_fmt, return to RUN.
  - If req_valid[drain_id] has dropped: return to RUN without a grant.
- Requesters that match cur_fmt are not granted during DRAIN. This prevents starvation of the format switcher.
- Simultaneous events: a response retiring and a new issue in the same cycle are independent. inflight accounts for both.
- Reset values: req_ready=0 during rst, all tag stages invalid, resp_valid=0, resp_id=0, resp_r=0, fpu_*=0, cur_fmt=0, rr=0, state RUN, busy=0.
- Reset mid-operation: all in-flight tags are cleared. Results later emerging on fpu_r never produce resp_valid.
- Requesters must hold req_* stable while valid and not ready (bench assertion).

Test Plan:
- Single op: req0 Add FP32, X=0x3F800000, Y=0x40000000; the bench FPU model returns 0x40400000 -> resp_valid exactly 5 cycles after handshake (LAT=3), resp_id=0, resp_r=0x40400000.
- Back-to-back issue: req1 issues Mul 0x40000000*0x40400000 on 4 consecutive cycles -> one grant per cycle; four consecutive resp pulses, all 0x40C00000, id=1, in order.
- Round-robin fairness: all 4 requesters valid continuously with FP32 ops -> grant order 0,1,2,3,0,1,...; each requester receives exactly 25% of grants over 40 cycles.
- Format switch: req0 FP32 issues 2 ops, then req1 presents FP16 Add X=0x00003C00, Y=0x00003C00 while req0 remains FP32-valid -> state DRAIN, no grants until inflight==0; req1 granted next with fpu_fmt=1; resp_r=0x00004000, id=1; req0 granted after, which triggers another drain.
- Drain abort: enter DRAIN for req2, then drop req_valid[2] before inflight reaches 0 -> return to RUN without a grant; cur_fmt unchanged.
- Reset mid-flight: assert rst for 1 cycle with 3 ops in flight -> no resp_valid afterward; busy=0, rr=0, cur_fmt=0 on the cycle after rst deasserts.
